// File: rtl/pc_pkg.sv
// Shared fetch-stage PC definitions: datapath width, reset vector and
// PC source select encoding.
package pc_pkg;

  localparam int unsigned     XLEN           = 32;
  localparam logic [XLEN-1:0] PC_RESET_VALUE = 32'h0000_0000;

  typedef enum logic {
    PC_SEL_SEQ      = 1'b0,
    PC_SEL_REDIRECT = 1'b1
  } pc_sel_e;

endpackage

// File: rtl/mux_pc.sv
// Next-PC source select for fetch: sequential (A) or redirect (B), optionally
// registered so the output is the PC register itself.
module mux_pc
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE),
  parameter bit               REGISTERED  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Operator,
  output logic [WIDTH-1:0] MUX_PC_Result
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] next_d;

  assign sel = pc_sel_e'(Operator);

  // An unknown select propagates as X instead of silently picking A.
  always_comb begin
    next_d = 'x;
    case (sel)
      PC_SEL_SEQ:      next_d = A;
      PC_SEL_REDIRECT: next_d = B;
      default:         next_d = 'x;
    endcase
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] result_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_q <= RESET_VALUE;
        end else begin
          result_q <= next_d;
        end
      end

      assign MUX_PC_Result = result_q;
    end else begin : g_comb
      logic unused_clk_rst;

      assign unused_clk_rst = clk ^ rst_n;
      assign MUX_PC_Result  = next_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux_pc.sv
// Directed self-checking bench for mux_pc, covering the registered and the
// combinational build side by side on the same stimulus.
module tb_mux_pc;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic [31:0] op_wide;
  logic [31:0] res_reg;
  logic [31:0] res_comb;

  int tests_run;
  int failures;

  mux_pc #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0000_0000),
    .REGISTERED (1'b1)
  ) u_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (a),
    .B            (b),
    .Operator     (op),
    .MUX_PC_Result(res_reg)
  );

  mux_pc #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0000_0000),
    .REGISTERED (1'b0)
  ) u_comb (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (a),
    .B            (b),
    .Operator     (op),
    .MUX_PC_Result(res_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0t required < 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a     = 32'h0000_0001;
    b     = 32'h0000_0002;
    op    = 1'b1;
    #1;
    tests_run++;
    if (res_reg !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_initial: got %h required %h", res_reg, 32'h0000_0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (res_reg !== 32'h0000_0000) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h required %h", i, res_reg, 32'h0000_0000);
      end
    end
    tests_run++;
    if (res_comb !== 32'h0000_0002) begin
      failures++;
      $display("FAIL comb_ignores_reset: got %h required %h", res_comb, 32'h0000_0002);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (res_reg !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_release_no_edge: got %h required %h", res_reg, 32'h0000_0000);
    end
    tick();
    tests_run++;
    if (res_reg !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_first_edge: got %h required %h", res_reg, 32'h0000_0002);
    end
  endtask

  task automatic test_select_a();
    a  = 32'h0000_0001;
    b  = 32'h0000_0000;
    op = 1'b0;
    #1;
    tests_run++;
    if (res_comb !== 32'h0000_0001) begin
      failures++;
      $display("FAIL comb_sel_a: got %h required %h", res_comb, 32'h0000_0001);
    end
    tests_run++;
    if (res_reg !== 32'h0000_0002) begin
      failures++;
      $display("FAIL sel_a_latency: got %h required %h", res_reg, 32'h0000_0002);
    end
    tick();
    tests_run++;
    if (res_reg !== 32'h0000_0001) begin
      failures++;
      $display("FAIL sel_a: got %h required %h", res_reg, 32'h0000_0001);
    end
    op = 1'b1;
    #1;
    tests_run++;
    if (res_comb !== 32'h0000_0000) begin
      failures++;
      $display("FAIL comb_sel_a_then_b: got %h required %h", res_comb, 32'h0000_0000);
    end
    tick();
    tests_run++;
    if (res_reg !== 32'h0000_0000) begin
      failures++;
      $display("FAIL sel_a_then_b: got %h required %h", res_reg, 32'h0000_0000);
    end
  endtask

  task automatic test_select_b();
    a  = 32'h0000_0000;
    b  = 32'h0000_0001;
    op = 1'b1;
    #1;
    tests_run++;
    if (res_comb !== 32'h0000_0001) begin
      failures++;
      $display("FAIL comb_sel_b: got %h required %h", res_comb, 32'h0000_0001);
    end
    tick();
    tests_run++;
    if (res_reg !== 32'h0000_0001) begin
      failures++;
      $display("FAIL sel_b: got %h required %h", res_reg, 32'h0000_0001);
    end
    // Wide value truncated to its LSB on the way into the 1-bit select.
    op = 1'b0;
    a  = 32'h0000_00AA;
    b  = 32'h0000_0055;
    tick();
    op_wide = 32'd5;
    op      = op_wide[0];
    #1;
    tests_run++;
    if (res_comb !== 32'h0000_0055) begin
      failures++;
      $display("FAIL comb_sel_wide5: got %h required %h", res_comb, 32'h0000_0055);
    end
    tick();
    tests_run++;
    if (res_reg !== 32'h0000_0055) begin
      failures++;
      $display("FAIL sel_wide5: got %h required %h", res_reg, 32'h0000_0055);
    end
  endtask

  task automatic test_full_width();
    logic [31:0] exp_seq [3];
    logic        op_seq  [3];
    exp_seq[0] = 32'hFFFF_FFFF;
    exp_seq[1] = 32'h8000_0000;
    exp_seq[2] = 32'hFFFF_FFFF;
    op_seq[0]  = 1'b0;
    op_seq[1]  = 1'b1;
    op_seq[2]  = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      op = op_seq[i];
      #1;
      tests_run++;
      if (res_comb !== exp_seq[i]) begin
        failures++;
        $display("FAIL comb_full_width[%0d]: got %h required %h", i, res_comb, exp_seq[i]);
      end
      tick();
      tests_run++;
      if (res_reg !== exp_seq[i]) begin
        failures++;
        $display("FAIL full_width[%0d]: got %h required %h", i, res_reg, exp_seq[i]);
      end
    end
  endtask

  task automatic test_between_edges();
    a  = 32'hCAFE_0004;
    b  = 32'hDEAD_BEEF;
    op = 1'b0;
    tick();
    a  = 32'h0BAD_F00D;
    op = 1'b1;
    #2;
    tests_run++;
    if (res_reg !== 32'hCAFE_0004) begin
      failures++;
      $display("FAIL between_edges_hold: got %h required %h", res_reg, 32'hCAFE_0004);
    end
    op = 1'b0;
    tick();
    tests_run++;
    if (res_reg !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL between_edges_sample: got %h required %h", res_reg, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_async_reset();
    a  = 32'h1234_5678;
    b  = 32'h0000_0000;
    op = 1'b0;
    tick();
    tests_run++;
    if (res_reg !== 32'h1234_5678) begin
      failures++;
      $display("FAIL async_pre: got %h required %h", res_reg, 32'h1234_5678);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (res_reg !== 32'h0000_0000) begin
      failures++;
      $display("FAIL async_assert: got %h required %h", res_reg, 32'h0000_0000);
    end
    tests_run++;
    if (res_comb !== 32'h1234_5678) begin
      failures++;
      $display("FAIL comb_async_ignored: got %h required %h", res_comb, 32'h1234_5678);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (res_reg !== 32'h0000_0000) begin
      failures++;
      $display("FAIL async_release_hold: got %h required %h", res_reg, 32'h0000_0000);
    end
    tick();
    tests_run++;
    if (res_reg !== 32'h1234_5678) begin
      failures++;
      $display("FAIL async_resume: got %h required %h", res_reg, 32'h1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic        ov [4];
    logic [31:0] ev [4];
    av[0] = 32'h0000_1000; bv[0] = 32'h0000_2000; ov[0] = 1'b1; ev[0] = 32'h0000_2000;
    av[1] = 32'h0000_2004; bv[1] = 32'h0000_3000; ov[1] = 1'b0; ev[1] = 32'h0000_2004;
    av[2] = 32'h0000_2008; bv[2] = 32'h7FFF_FFFE; ov[2] = 1'b1; ev[2] = 32'h7FFF_FFFE;
    av[3] = 32'h8000_0001; bv[3] = 32'h0000_0000; ov[3] = 1'b0; ev[3] = 32'h8000_0001;
    a  = av[0];
    b  = bv[0];
    op = ov[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (res_reg !== ev[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, res_reg, ev[i]);
      end
      if (i < 3) begin
        a  = av[i+1];
        b  = bv[i+1];
        op = ov[i+1];
      end
    end
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    op_wide   = '0;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    #2;
    test_reset();
    test_select_a();
    test_select_b();
    test_full_width();
    test_between_edges();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
